// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM port arbiter: FSM states, port indices and
// the operation encoding that the grant register carries.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    typedef enum logic {
        OP_RD,
        OP_WR
    } op_t;

    localparam logic PORT_D = 1'b0;
    localparam logic PORT_I = 1'b1;

    // Starvation counter width; it must hold the largest legal STARVE_LIMIT (15).
    localparam int unsigned STARVE_CNT_W = 4;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Bundle of the two requester ports and the downstream SRAM controller port.
// master: requesters plus controller; slave: the arbiter itself.
interface sram_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);

    logic              d_rd_en;
    logic              d_wr_en;
    logic [ADDR_W-1:0] d_address;
    logic [DATA_W-1:0] d_write_data;
    logic              d_ready;
    logic [DATA_W-1:0] d_read_data;

    logic              i_rd_en;
    logic [ADDR_W-1:0] i_address;
    logic              i_ready;
    logic [DATA_W-1:0] i_read_data;

    logic              mem_rd_en;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_read_data;

    logic              owner;

    modport master (
        output d_rd_en, d_wr_en, d_address, d_write_data,
        input  d_ready, d_read_data,
        output i_rd_en, i_address,
        input  i_ready, i_read_data,
        input  mem_rd_en, mem_wr_en, mem_address, mem_write_data,
        output mem_ready, mem_read_data,
        input  owner
    );

    modport slave (
        input  d_rd_en, d_wr_en, d_address, d_write_data,
        output d_ready, d_read_data,
        input  i_rd_en, i_address,
        output i_ready, i_read_data,
        output mem_rd_en, mem_wr_en, mem_address, mem_write_data,
        input  mem_ready, mem_read_data,
        output owner
    );

endinterface

// File: rtl/sram_arb_pick.sv
// Combinational winner selection between port D and port I.
// SRAM_ARB_RR_EN selects round-robin; otherwise fixed D priority with a starvation guard.
module sram_arb_pick
    import sram_arb_pkg::*;
(
    input  logic d_req,
    input  logic i_req,
    input  logic last_owner,
    input  logic at_limit,
    output logic grant_valid,
    output logic grant_port
);

    assign grant_valid = d_req | i_req;

`ifdef SRAM_ARB_RR_EN
    logic unused_at_limit;
    assign unused_at_limit = at_limit;

    always_comb begin
        grant_port = PORT_D;
        if (d_req && i_req) begin
            grant_port = ~last_owner;
        end else if (i_req) begin
            grant_port = PORT_I;
        end
    end
`else
    logic unused_last_owner;
    assign unused_last_owner = last_owner;

    // I only overtakes a requesting D once D has been favoured STARVE_LIMIT times in a row.
    always_comb begin
        grant_port = PORT_D;
        if (i_req && (!d_req || at_limit)) begin
            grant_port = PORT_I;
        end
    end
`endif

endmodule

// File: rtl/sram_port_arbiter.sv
// Serialises port D (load/store) and port I (fetch) onto one SRAM controller port.
// Arbitration policy is chosen in sram_arb_pick by SRAM_ARB_RR_EN.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic                clk,
    input logic                rst,
    sram_port_arbiter_if.slave bus
);

    state_t                  state;
    op_t                     g_op;
    logic                    owner_q;
    logic                    mem_rd_q;
    logic                    mem_wr_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [DATA_W-1:0]       wdata_q;
    logic [DATA_W-1:0]       d_buf;
    logic [DATA_W-1:0]       i_buf;
    logic [STARVE_CNT_W-1:0] starve_cnt;

    logic d_req;
    logic i_req;
    logic at_limit;
    logic grant_valid;
    logic grant_port;
    op_t  win_op;

    assign d_req    = bus.d_rd_en | bus.d_wr_en;
    assign i_req    = bus.i_rd_en;
    assign at_limit = (starve_cnt == STARVE_CNT_W'(STARVE_LIMIT));

    sram_arb_pick u_pick (
        .d_req       (d_req),
        .i_req       (i_req),
        .last_owner  (owner_q),
        .at_limit    (at_limit),
        .grant_valid (grant_valid),
        .grant_port  (grant_port)
    );

    // A D request with both enables high is a write.
    always_comb begin
        win_op = OP_RD;
        if (grant_port == PORT_D && bus.d_wr_en) begin
            win_op = OP_WR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            g_op       <= OP_RD;
            owner_q    <= PORT_D;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            d_buf      <= '0;
            i_buf      <= '0;
            starve_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner_q  <= grant_port;
                        g_op     <= win_op;
                        mem_rd_q <= (win_op == OP_RD);
                        mem_wr_q <= (win_op == OP_WR);
                        if (grant_port == PORT_D) begin
                            addr_q  <= bus.d_address;
                            wdata_q <= bus.d_write_data;
                            if (i_req && !at_limit) begin
                                starve_cnt <= starve_cnt + 1'b1;
                            end
                        end else begin
                            addr_q     <= bus.i_address;
                            wdata_q    <= '0;
                            starve_cnt <= '0;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (bus.mem_ready) begin
                        if (g_op == OP_RD) begin
                            if (owner_q == PORT_D) begin
                                d_buf <= bus.mem_read_data;
                            end else begin
                                i_buf <= bus.mem_read_data;
                            end
                        end
                        mem_rd_q <= 1'b0;
                        mem_wr_q <= 1'b0;
                        state    <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Ready drops combinationally with a new request; a withdrawn request sees ready at once.
    assign bus.d_ready = !d_req || (state == RESP && owner_q == PORT_D);
    assign bus.i_ready = !i_req || (state == RESP && owner_q == PORT_I);

    assign bus.d_read_data    = d_buf;
    assign bus.i_read_data    = i_buf;
    assign bus.mem_rd_en      = mem_rd_q;
    assign bus.mem_wr_en      = mem_wr_q;
    assign bus.mem_address    = addr_q;
    assign bus.mem_write_data = wdata_q;
    assign bus.owner          = owner_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter with a behavioural SRAM controller
// and a scoreboard of expected downstream transactions.
module tb_sram_port_arbiter;
    import sram_arb_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    sram_port_arbiter #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .STARVE_LIMIT (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    int          issues      = 0;
    int unsigned busy_n      = 5;
    logic [95:0] exp_q[$];

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [95:0] txn(input logic port, input logic wr,
                                        input logic [31:0] a, input logic [31:0] d);
        return {29'd0, port, ~wr, wr, a, (wr ? d : 32'd0)};
    endfunction

    // Behavioural SRAM controller: accepts when idle, busy for busy_n cycles, then one ready cycle.
    typedef enum logic [1:0] {C_IDLE, C_BUSY, C_DONE} ctrl_t;
    ctrl_t       c_state;
    int unsigned c_cnt;
    logic [31:0] c_data;
    logic [31:0] mem_model [0:1023];

    always @(posedge clk) begin
        if (rst) begin
            c_state           <= C_IDLE;
            c_cnt             <= 0;
            c_data            <= '0;
            bus.mem_ready     <= 1'b1;
            bus.mem_read_data <= '0;
            for (int k = 0; k < 1024; k++) begin
                mem_model[k] <= 32'(k * 4) ^ 32'h5A5A_5A5A;
            end
            mem_model[10'h104] <= 32'hDEAD_BEEF;
        end else begin
            case (c_state)
                C_IDLE: begin
                    if (bus.mem_rd_en || bus.mem_wr_en) begin
                        if (bus.mem_wr_en) begin
                            mem_model[bus.mem_address[11:2]] <= bus.mem_write_data;
                        end
                        c_data        <= mem_model[bus.mem_address[11:2]];
                        c_cnt         <= busy_n;
                        bus.mem_ready <= 1'b0;
                        c_state       <= C_BUSY;
                    end
                end
                C_BUSY: begin
                    if (c_cnt <= 1) begin
                        bus.mem_ready     <= 1'b1;
                        bus.mem_read_data <= c_data;
                        c_state           <= C_DONE;
                    end else begin
                        c_cnt <= c_cnt - 1;
                    end
                end
                default: c_state <= C_IDLE;
            endcase
        end
    end

    // Scoreboard: every new downstream transaction is popped and compared.
    logic prev_en;
    always @(negedge clk) begin
        if (rst) begin
            prev_en <= 1'b0;
        end else begin
            if ((bus.mem_rd_en || bus.mem_wr_en) && !prev_en) begin
                issues <= issues + 1;
                check("issue_pending", 96'(exp_q.size() != 0), 96'd1);
                if (exp_q.size() != 0) begin
                    check("issue",
                          {29'd0, bus.owner, bus.mem_rd_en, bus.mem_wr_en, bus.mem_address,
                           (bus.mem_wr_en ? bus.mem_write_data : 32'd0)},
                          exp_q.pop_front());
                end
            end
            prev_en <= bus.mem_rd_en || bus.mem_wr_en;
        end
    end

    // Holds each active request until its ready is seen, counting the low cycles before it.
    task automatic service(input int budget, output int d_lows, output int i_lows,
                           output logic [31:0] d_data, output logic [31:0] i_data);
        logic d_hit;
        logic i_hit;
        d_lows = 0;
        i_lows = 0;
        d_data = '0;
        i_data = '0;
        for (int c = 0; c < budget; c++) begin
            if (!(bus.d_rd_en || bus.d_wr_en || bus.i_rd_en)) break;
            @(negedge clk);
            d_hit = 1'b0;
            i_hit = 1'b0;
            if (bus.d_rd_en || bus.d_wr_en) begin
                if (bus.d_ready) begin
                    d_hit  = 1'b1;
                    d_data = bus.d_read_data;
                end else begin
                    d_lows++;
                end
            end
            if (bus.i_rd_en) begin
                if (bus.i_ready) begin
                    i_hit  = 1'b1;
                    i_data = bus.i_read_data;
                end else begin
                    i_lows++;
                end
            end
            @(posedge clk);
            #1;
            if (d_hit) begin
                bus.d_rd_en = 1'b0;
                bus.d_wr_en = 1'b0;
            end
            if (i_hit) bus.i_rd_en = 1'b0;
        end
        check("d_timeout", 96'(bus.d_rd_en | bus.d_wr_en), 96'd0);
        check("i_timeout", 96'(bus.i_rd_en), 96'd0);
        bus.d_rd_en = 1'b0;
        bus.d_wr_en = 1'b0;
        bus.i_rd_en = 1'b0;
    endtask

    task automatic wait_issue(input int base);
        for (int c = 0; c < 20 && issues == base; c++) begin
            @(negedge clk);
            #1;
        end
        check("issue_seen", 96'(issues - base), 96'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          dl;
        int          il;
        int          base;
        logic [31:0] dd;
        logic [31:0] id;

        rst              = 1'b1;
        bus.d_rd_en      = 1'b0;
        bus.d_wr_en      = 1'b0;
        bus.d_address    = '0;
        bus.d_write_data = '0;
        bus.i_rd_en      = 1'b0;
        bus.i_address    = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_d_ready", 96'(bus.d_ready), 96'd1);
        check("rst_i_ready", 96'(bus.i_ready), 96'd1);
        check("rst_mem_rd_en", 96'(bus.mem_rd_en), 96'd0);
        check("rst_mem_wr_en", 96'(bus.mem_wr_en), 96'd0);
        check("rst_owner", 96'(bus.owner), 96'd0);
        check("rst_mem_address", 96'(bus.mem_address), 96'd0);
        check("rst_d_read_data", 96'(bus.d_read_data), 96'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Uncontended D read, controller busy 5 cycles
        busy_n = 5;
        exp_q.push_back(txn(PORT_D, 1'b0, 32'h0000_0410, 32'd0));
        bus.d_rd_en   = 1'b1;
        bus.d_address = 32'h0000_0410;
        service(100, dl, il, dd, id);
        check("d_read_lat", 96'(dl), 96'd8);
        check("d_read_data", 96'(dd), 96'hDEAD_BEEF);

        // D write contending with I read
        busy_n = 3;
`ifdef SRAM_ARB_RR_EN
        exp_q.push_back(txn(PORT_I, 1'b0, 32'h0000_0000, 32'd0));
        exp_q.push_back(txn(PORT_D, 1'b1, 32'h0000_0420, 32'h1234_5678));
`else
        exp_q.push_back(txn(PORT_D, 1'b1, 32'h0000_0420, 32'h1234_5678));
        exp_q.push_back(txn(PORT_I, 1'b0, 32'h0000_0000, 32'd0));
`endif
        bus.d_wr_en      = 1'b1;
        bus.d_address    = 32'h0000_0420;
        bus.d_write_data = 32'h1234_5678;
        bus.i_rd_en      = 1'b1;
        bus.i_address    = 32'h0000_0000;
        service(100, dl, il, dd, id);
`ifdef SRAM_ARB_RR_EN
        check("pair_i_lat", 96'(il), 96'd6);
        check("pair_d_lat", 96'(dl), 96'd13);
`else
        check("pair_d_lat", 96'(dl), 96'd6);
        check("pair_i_lat", 96'(il), 96'd13);
`endif
        check("pair_i_data", 96'(id), 96'h5A5A_5A5A);
        check("pair_d_stale", 96'(dd), 96'hDEAD_BEEF);

        // Continuous D and I requests: starvation guard or round-robin
        busy_n = 1;
        base   = issues;
        for (int k = 0; k < 10; k++) begin
`ifdef SRAM_ARB_RR_EN
            if (k % 2 == 0) exp_q.push_back(txn(PORT_I, 1'b0, 32'h0000_0600, 32'd0));
            else            exp_q.push_back(txn(PORT_D, 1'b0, 32'h0000_0500, 32'd0));
`else
            if (k == 4 || k == 9) exp_q.push_back(txn(PORT_I, 1'b0, 32'h0000_0600, 32'd0));
            else                  exp_q.push_back(txn(PORT_D, 1'b0, 32'h0000_0500, 32'd0));
`endif
        end
        bus.d_rd_en   = 1'b1;
        bus.d_address = 32'h0000_0500;
        bus.i_rd_en   = 1'b1;
        bus.i_address = 32'h0000_0600;
        for (int c = 0; c < 300 && issues < base + 10; c++) begin
            @(negedge clk);
            #1;
        end
        check("stream_grants", 96'(issues - base), 96'd10);
        @(posedge clk);
        #1;
        bus.d_rd_en = 1'b0;
        bus.i_rd_en = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("stream_drained", 96'(exp_q.size()), 96'd0);

        // D withdraws its read during WAIT; I queues behind it
        busy_n = 6;
        exp_q.push_back(txn(PORT_D, 1'b0, 32'h0000_0700, 32'd0));
        bus.d_rd_en   = 1'b1;
        bus.d_address = 32'h0000_0700;
        wait_issue(issues);
        @(posedge clk);
        #1;
        bus.d_rd_en   = 1'b0;
        bus.i_rd_en   = 1'b1;
        bus.i_address = 32'h0000_0800;
        exp_q.push_back(txn(PORT_I, 1'b0, 32'h0000_0800, 32'd0));
        @(negedge clk);
        check("wd_d_ready", 96'(bus.d_ready), 96'd1);
        check("wd_mem_rd_en", 96'(bus.mem_rd_en), 96'd1);
        check("wd_i_ready", 96'(bus.i_ready), 96'd0);
        bus.i_rd_en = 1'b1;
        service(100, dl, il, dd, id);
        check("wd_i_data", 96'(id), 96'(32'h0000_0800 ^ 32'h5A5A_5A5A));

        // Reset during WAIT with an I request pending
        busy_n = 8;
        exp_q.push_back(txn(PORT_I, 1'b0, 32'h0000_0900, 32'd0));
        bus.i_rd_en   = 1'b1;
        bus.i_address = 32'h0000_0900;
        wait_issue(issues);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.push_back(txn(PORT_I, 1'b0, 32'h0000_0900, 32'd0));
        @(negedge clk);
        check("mrst_mem_rd_en", 96'(bus.mem_rd_en), 96'd0);
        check("mrst_mem_wr_en", 96'(bus.mem_wr_en), 96'd0);
        check("mrst_owner", 96'(bus.owner), 96'd0);
        check("mrst_d_buf", 96'(bus.d_read_data), 96'd0);
        check("mrst_i_buf", 96'(bus.i_read_data), 96'd0);
        check("mrst_i_ready", 96'(bus.i_ready), 96'd0);
        service(100, dl, il, dd, id);
        check("mrst_i_data", 96'(id), 96'(32'h0000_0900 ^ 32'h5A5A_5A5A));

        // Both D enables high: a write, read data stays stale
        busy_n = 2;
        exp_q.push_back(txn(PORT_D, 1'b1, 32'h0000_0420, 32'hCAFE_F00D));
        bus.d_rd_en      = 1'b1;
        bus.d_wr_en      = 1'b1;
        bus.d_address    = 32'h0000_0420;
        bus.d_write_data = 32'hCAFE_F00D;
        service(100, dl, il, dd, id);
        check("rw_lat", 96'(dl), 96'd5);
        check("rw_stale", 96'(dd), 96'd0);

        // Read back the written word
        exp_q.push_back(txn(PORT_D, 1'b0, 32'h0000_0420, 32'd0));
        bus.d_rd_en   = 1'b1;
        bus.d_address = 32'h0000_0420;
        service(100, dl, il, dd, id);
        check("rb_lat", 96'(dl), 96'd5);
        check("rb_data", 96'(dd), 96'hCAFE_F00D);

        repeat (4) @(posedge clk);
        #1;
        check("final_drained", 96'(exp_q.size()), 96'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
